smc777_text_vid: RTL and testbench
==================================

# smc777_text_vid

Text-mode pixel generator sitting directly downstream of the mc6845 CRTC in the SMC-777 core. It paces the CRTC with a character clock enable and consumes its MA/RA/DE/CURSOR/sync outputs. It fetches character and attribute bytes from VRAM and the glyph row from font ROM, then shifts out 8 pixels per character as 4-bit RGBI. Sync and display-enable are delayed to stay aligned with the pixels.

## Interface
Parameters:
- `FONT_ROWS`, 8: glyph height; RA values at or above it render blank.

Ports:
- `clk` in 1: system clock (the one clock).
- `reset_n` in 1: synchronous, active-low reset.
- `pix_ce` in 1: pixel clock enable; asserted at most every 2nd `clk`.
- `char_ce` out 1: one-`clk` pulse on the `pix_ce` that ends a character cell; drives CRTC CLKEN.
- `ma` in 14: CRTC memory address (valid the `clk` after `char_ce`).
- `ra` in 5: CRTC raster address.
- `de` in 1: CRTC display enable.
- `cursor` in 1: CRTC cursor flag.
- `hsync_i`, `vsync_i` in 1 each: CRTC syncs.
- `vram_addr` out 12: VRAM read address.
- `vram_rd` out 1: VRAM read strobe.
- `vram_data` in 8: VRAM data, valid 1 `clk` after address.
- `font_addr` out 11: {char[7:0], ra[2:0]}.
- `font_data` in 8: glyph row, valid 1 `clk` after address, MSB = leftmost pixel.
- `bg_color` in 4: global background RGBI.
- `rgbi` out 4: pixel colour {R,G,B,I}.
- `hsync_o`, `vsync_o`, `de_o` out 1 each: syncs and DE delayed by one character.

## Operation
- Pixel counter `px[2:0]` increments on `pix_ce`. `char_ce` = `pix_ce & px==7`.
- Fetch FSM, advancing every `clk`:
  - IDLE: waits for the `clk` after `char_ce`, then samples ma/ra/de/cursor.
  - If sampled de=0: stage pattern 0 and attr 0, return to IDLE.
  - CHR: `vram_addr={ma[10:0],0}`, `vram_rd=1`.
  - ATR: `vram_addr={ma[10:0],1}`, `vram_rd=1`.
  - FNT: latch char; `font_addr={char,ra[2:0]}`; latch attr.
  - DONE: latch font_data into staged pattern, return to IDLE.
  - Staged pattern is forced to 0 if ra>=FONT_ROWS.
  - Fetch completes 5 `clk` after `char_ce`.
- Attribute bits:
  - [2:0] fg RGB, [3] fg intensity.
  - [4] reverse: swap fg/bg.
  - [5] blink: pattern forced 0 while blink phase=1.
- Cursor: if the sampled cursor=1, the pattern is inverted while cursor phase=1.
- Frame counter (5 bits) increments on each vsync_i rising edge. Cursor phase = bit 3; blink phase = bit 4.
- On `char_ce`:
  - Staged pattern/colours load into the shift register and colour regs.
  - hsync_i/vsync_i/de captured into `hsync_o`/`vsync_o`/`de_o`.
- On each `pix_ce`, the shifter shifts left.
  - `rgbi` = fg if the shifter MSB=1, else bg.
  - `rgbi`=0 whenever `de_o`=0.

## Timing
- Reset: `px`, FSM=IDLE, shifter, staged regs and frame counter cleared to 0. All outputs are 0: `char_ce`, `vram_addr`, `vram_rd`, `font_addr`, `rgbi`, syncs, `de_o`.
- Latency: one character cell (8 `pix_ce`) from CRTC outputs to first pixel. Syncs are delayed by the same amount.
- `rgbi` changes only on `clk` edges where `pix_ce`=1. It holds between enables.
- With `pix_ce` every 2nd `clk`, a character spans 16 `clk`. The fetch (5 `clk`) always completes before the next load. Faster `pix_ce` is a usage error; output is then undefined.
- `vram_rd` is high for exactly 2 `clk` per displayed character and never while sampled de=0.
- `pix_ce` during a fetch does not disturb the FSM.
- Reset asserted mid-line takes effect on the next `clk`. The first `char_ce` after release occurs on the 8th `pix_ce`.
- Frame counter wraps 31→0.

## Structure
- Package `smc777_vid_pkg`:
  - fetch state enum (IDLE, CHR, ATR, FNT, DONE);
  - attribute bit positions (ATTR_REV=4, ATTR_BLINK=5);
  - phase bit indices (CUR_PHASE=3, BLINK_PHASE=4).
- Sub-module `smc777_vid_fetch`: the FSM plus VRAM/font address and staging regs. The top keeps the counters, shifter and colour mux.

## Test plan
- Reset release, `pix_ce` every 2 `clk` -> `char_ce` pulses every 16 `clk`, first on the 8th `pix_ce`. All outputs 0 until then.
- ma=0x005, ra=2, de=1; VRAM[0x00A]=0x41, [0x00B]=0x0C; font[0x20A]=0xA5; bg=0 -> `vram_addr` 0x00A then 0x00B, `font_addr`=0x20A. Next cell `rgbi` = C,0,C,0,0,C,0,C.
- Same setup with attr 0x1C (reverse) -> pixels 0,C,0,C,C,0,C,0.
- de=0 at sample -> no `vram_rd`. Next cell `de_o`=0 and `rgbi`=0 for all 8 pixels.
- ra=9, de=1 -> pattern 0, so 8 pixels of bg. With cursor=1 after 8 vsync edges -> 8 pixels of fg.
- hsync_i rises at a `char_ce` -> `hsync_o` rises exactly at the next `char_ce`.

Source files
------------

// File: rtl/smc777_vid_pkg.sv
// Shared types and constants for the SMC-777 text-mode video path.
package smc777_vid_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CHR  = 3'd1,
    ATR  = 3'd2,
    FNT  = 3'd3,
    DONE = 3'd4
  } fetch_state_t;

  localparam int ATTR_REV    = 4;
  localparam int ATTR_BLINK  = 5;
  localparam int CUR_PHASE   = 3;
  localparam int BLINK_PHASE = 4;

  // One character cell's worth of fetched data, waiting for the next char_ce.
  typedef struct packed {
    logic [7:0] pat;
    logic [7:0] attr;
    logic       cursor;
  } stage_t;

endpackage

// File: rtl/smc777_vid_fetch.sv
// Per-character fetch: samples the CRTC after char_ce, reads char/attr from VRAM and the glyph row from font ROM.
// Staged result is ready 5 clk after char_ce; no backpressure, one fetch per character cell.
module smc777_vid_fetch
  import smc777_vid_pkg::*;
#(
  parameter int FONT_ROWS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [13:0] ma,
  input  logic [4:0]  ra,
  input  logic        de,
  input  logic        cursor,
  output logic [11:0] vram_addr,
  output logic        vram_rd,
  input  logic [7:0]  vram_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output stage_t      stage
);

  fetch_state_t state, state_nxt;
  logic [10:0]  ma_q;
  logic [4:0]   ra_q;
  logic         cur_q;
  logic [7:0]   chr_q;
  logic [7:0]   attr_q;
  logic         blank;
  logic         unused_ma;

  assign unused_ma = ^ma[13:11];
  assign blank     = ({27'd0, ra_q} >= 32'(FONT_ROWS));
  assign font_addr = {chr_q, ra_q[2:0]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      ma_q   <= '0;
      ra_q   <= '0;
      cur_q  <= 1'b0;
      chr_q  <= '0;
      attr_q <= '0;
      stage  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            ma_q  <= ma[10:0];
            ra_q  <= ra;
            cur_q <= cursor;
            if (!de) stage <= '0;
          end
        end
        ATR:  chr_q  <= vram_data;
        FNT:  attr_q <= vram_data;
        DONE: begin
          stage.pat    <= blank ? 8'h00 : font_data;
          stage.attr   <= attr_q;
          stage.cursor <= cur_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    vram_addr = '0;
    vram_rd   = 1'b0;
    case (state)
      IDLE: if (start && de) state_nxt = CHR;
      CHR: begin
        vram_addr = {ma_q, 1'b0};
        vram_rd   = 1'b1;
        state_nxt = ATR;
      end
      ATR: begin
        vram_addr = {ma_q, 1'b1};
        vram_rd   = 1'b1;
        state_nxt = FNT;
      end
      FNT:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/smc777_text_vid.sv
// Text-mode pixel generator behind the mc6845: paces the CRTC, shifts out 8 RGBI pixels per character.
// Pixels, syncs and DE lag the CRTC by one character cell; no backpressure, pix_ce at most every 2nd clk.
module smc777_text_vid
  import smc777_vid_pkg::*;
#(
  parameter int FONT_ROWS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_ce,
  output logic        char_ce,
  input  logic [13:0] ma,
  input  logic [4:0]  ra,
  input  logic        de,
  input  logic        cursor,
  input  logic        hsync_i,
  input  logic        vsync_i,
  output logic [11:0] vram_addr,
  output logic        vram_rd,
  input  logic [7:0]  vram_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic [3:0]  bg_color,
  output logic [3:0]  rgbi,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o
);

  logic [2:0] px;
  logic       char_ce_d;
  logic       vsync_q;
  logic [4:0] frame;
  logic [7:0] shifter;
  logic [3:0] fg_q, bg_q;
  stage_t     stage;
  logic [7:0] pat_eff;
  logic [3:0] fg_nxt, bg_nxt;
  logic       unused_attr;

  assign char_ce     = pix_ce & (px == 3'd7);
  assign unused_attr = ^stage.attr[7:6];

  smc777_vid_fetch #(.FONT_ROWS(FONT_ROWS)) u_fetch (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (char_ce_d),
    .ma        (ma),
    .ra        (ra),
    .de        (de),
    .cursor    (cursor),
    .vram_addr (vram_addr),
    .vram_rd   (vram_rd),
    .vram_data (vram_data),
    .font_addr (font_addr),
    .font_data (font_data),
    .stage     (stage)
  );

  // Blink blanks the glyph first so a cursor still shows over a blinking character.
  always_comb begin
    pat_eff = stage.pat;
    if (stage.attr[ATTR_BLINK] && frame[BLINK_PHASE]) pat_eff = 8'h00;
    if (stage.cursor && frame[CUR_PHASE]) pat_eff = ~pat_eff;
    fg_nxt = stage.attr[3:0];
    bg_nxt = bg_color;
    if (stage.attr[ATTR_REV]) begin
      fg_nxt = bg_color;
      bg_nxt = stage.attr[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      px        <= '0;
      char_ce_d <= 1'b0;
      vsync_q   <= 1'b0;
      frame     <= '0;
      shifter   <= '0;
      fg_q      <= '0;
      bg_q      <= '0;
      hsync_o   <= 1'b0;
      vsync_o   <= 1'b0;
      de_o      <= 1'b0;
    end else begin
      char_ce_d <= char_ce;
      vsync_q   <= vsync_i;
      if (vsync_i && !vsync_q) frame <= frame + 5'd1;
      if (pix_ce) px <= px + 3'd1;
      if (char_ce) begin
        shifter <= pat_eff;
        fg_q    <= fg_nxt;
        bg_q    <= bg_nxt;
        hsync_o <= hsync_i;
        vsync_o <= vsync_i;
        de_o    <= de;
      end else if (pix_ce) begin
        shifter <= {shifter[6:0], 1'b0};
      end
    end
  end

  assign rgbi = !de_o ? 4'h0 : (shifter[7] ? fg_q : bg_q);

endmodule

// File: tb/tb_smc777_text_vid.sv
// Bench for smc777_text_vid: acts as CRTC, VRAM and font ROM, checks pixels against a per-cell model.
module tb_smc777_text_vid;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_ce = 1'b0;
  logic        char_ce;
  logic [13:0] ma = '0;
  logic [4:0]  ra = '0;
  logic        de = 1'b0;
  logic        cursor = 1'b0;
  logic        hsync_i = 1'b0;
  logic        vsync_i = 1'b0;
  logic [11:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_data = '0;
  logic [10:0] font_addr;
  logic [7:0]  font_data = '0;
  logic [3:0]  bg_color = '0;
  logic [3:0]  rgbi;
  logic        hsync_o, vsync_o, de_o;

  smc777_text_vid #(.FONT_ROWS(8)) dut (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .char_ce(char_ce),
    .ma(ma), .ra(ra), .de(de), .cursor(cursor),
    .hsync_i(hsync_i), .vsync_i(vsync_i),
    .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_data(vram_data),
    .font_addr(font_addr), .font_data(font_data),
    .bg_color(bg_color), .rgbi(rgbi),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o)
  );

  always #5 clk = ~clk;

  logic [7:0] vram [4096];
  logic [7:0] font [2048];

  always @(posedge clk) begin
    vram_data <= vram[vram_addr];
    font_data <= font[font_addr];
  end

  typedef struct packed {
    logic [7:0][3:0] pix;
    logic            de;
    logic            hs;
    logic            vs;
  } cell_t;

  cell_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    frame_m = 0;
  int    cell_no = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    pix_ce = ~pix_ce;
    #1;
  endtask

  // Drives one CRTC character cell and checks the output of the previous one during it.
  task automatic do_cell(input logic [13:0] m, input logic [4:0] r, input logic d,
                         input logic c, input logic hs, input logic vs, input logic [3:0] bg);
    cell_t      e, cur;
    logic [7:0] chr, atr, pat;
    logic [3:0] fgc, bgc, tmp;
    logic [11:0] exp_a;
    int         rd_n;
    if (vs && !vsync_i) frame_m = (frame_m + 1) % 32;
    ma = m; ra = r; de = d; cursor = c; hsync_i = hs; vsync_i = vs; bg_color = bg;

    chr = vram[{m[10:0], 1'b0}];
    atr = vram[{m[10:0], 1'b1}];
    pat = (r < 5'd8) ? font[{chr, r[2:0]}] : 8'h00;
    if (!d) begin pat = 8'h00; atr = 8'h00; end
    if (atr[5] && (frame_m / 16) % 2 == 1) pat = 8'h00;
    if (d && c && (frame_m / 8) % 2 == 1) pat = ~pat;
    fgc = atr[3:0];
    bgc = bg;
    if (atr[4]) begin tmp = fgc; fgc = bgc; bgc = tmp; end
    for (int p = 0; p < 8; p++) e.pix[p] = !d ? 4'h0 : (pat[7-p] ? fgc : bgc);
    e.de = d; e.hs = hs; e.vs = vs;

    cur = exp_q.pop_front();
    exp_q.push_back(e);
    rd_n = 0;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (rgbi !== cur.pix[i/2]) begin
        n_bad++;
        $display("FAIL rgbi cell=%0d clk=%0d got=%h exp=%h", cell_no, i, rgbi, cur.pix[i/2]);
      end
      if (i == 0) begin
        n_cmp++;
        if ({de_o, hsync_o, vsync_o} !== {cur.de, cur.hs, cur.vs}) begin
          n_bad++;
          $display("FAIL syncs cell=%0d got de/hs/vs=%b exp=%b", cell_no,
                   {de_o, hsync_o, vsync_o}, {cur.de, cur.hs, cur.vs});
        end
      end
      if (vram_rd === 1'b1) begin
        rd_n++;
        exp_a = {m[10:0], (rd_n == 2)};
        n_cmp++;
        if (vram_addr !== exp_a) begin
          n_bad++;
          $display("FAIL vram_addr cell=%0d rd=%0d got=%h exp=%h", cell_no, rd_n, vram_addr, exp_a);
        end
      end
      if (d && i == 3) begin
        n_cmp++;
        if (font_addr !== {chr, r[2:0]}) begin
          n_bad++;
          $display("FAIL font_addr cell=%0d got=%h exp=%h", cell_no, font_addr, {chr, r[2:0]});
        end
      end
      n_cmp++;
      if (char_ce !== (i == 15)) begin
        n_bad++;
        $display("FAIL char_ce cell=%0d clk=%0d got=%b exp=%b", cell_no, i, char_ce, (i == 15));
      end
      tick();
    end
    n_cmp++;
    if (rd_n != (d ? 2 : 0)) begin
      n_bad++;
      $display("FAIL vram_rd_count cell=%0d got=%0d exp=%0d", cell_no, rd_n, d ? 2 : 0);
    end
    cell_no++;
  endtask

  task automatic test_reset();
    int n;
    bit seen;
    reset_n = 1'b0; de = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0; cursor = 1'b0;
    ma = '0; ra = '0; bg_color = '0;
    repeat (4) tick();
    n_cmp++;
    if ({char_ce, vram_rd, rgbi, hsync_o, vsync_o, de_o, vram_addr, font_addr} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got ce=%b rd=%b rgbi=%h hs=%b vs=%b de=%b va=%h fa=%h exp=all0",
               char_ce, vram_rd, rgbi, hsync_o, vsync_o, de_o, vram_addr, font_addr);
    end
    reset_n = 1'b1;
    n = 0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (pix_ce) n++;
      n_cmp++;
      if (char_ce !== (pix_ce && n == 8)) begin
        n_bad++;
        $display("FAIL first_char_ce pix=%0d got=%b exp=%b", n, char_ce, (pix_ce && n == 8));
      end
      n_cmp++;
      if ({rgbi, vram_rd, de_o, hsync_o, vsync_o} !== '0) begin
        n_bad++;
        $display("FAIL post_reset_quiet pix=%0d got rgbi=%h rd=%b de=%b hs=%b vs=%b exp=0",
                 n, rgbi, vram_rd, de_o, hsync_o, vsync_o);
      end
      if (char_ce === 1'b1) seen = 1;
      tick();
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL first_char_ce_timeout got=none exp=pulse on 8th pix_ce");
    end
    exp_q.delete();
    exp_q.push_back('0);
    frame_m = 0;
  endtask

  task automatic test_basic();
    vram[12'h00A] = 8'h41;
    vram[12'h00B] = 8'h0C;
    font[11'h20A] = 8'hA5;
    do_cell(14'h005, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    do_cell(14'h005, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_reverse();
    vram[12'h00B] = 8'h1C;
    do_cell(14'h005, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    do_cell(14'h005, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_de_low();
    do_cell(14'h123, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h7);
    do_cell(14'h005, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'h7);
  endtask

  task automatic test_hsync();
    do_cell(14'h005, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2);
    do_cell(14'h006, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2);
    do_cell(14'h007, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
  endtask

  // Frame phases: cursor on at 8 vsyncs, blink at 16, counter wraps after 32.
  task automatic test_blank_cursor_blink();
    vram[12'h00B] = 8'h2C;
    do_cell(14'h005, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 4'h3);
    do_cell(14'h005, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3);
    for (int k = 0; k < 8; k++) begin
      do_cell(14'h005, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 4'h3);
      do_cell(14'h005, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 4'h3);
    end
    do_cell(14'h005, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3);
    for (int k = 0; k < 24; k++) begin
      do_cell(14'h005, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 4'h3);
      do_cell(14'h005, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3);
    end
    do_cell(14'h005, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 4'h3);
    do_cell(14'h005, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3);
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++)
      do_cell(14'($urandom), 5'($urandom_range(0, 11)), 1'($urandom_range(0, 3) != 0),
              1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0), 4'($urandom));
  endtask

  task automatic test_reset_midline();
    do_cell(14'h005, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 4'h5);
    ma = 14'h040; ra = 5'd1; de = 1'b1; hsync_i = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    n_cmp++;
    if ({vram_rd, rgbi, de_o, hsync_o, vsync_o} !== '0) begin
      n_bad++;
      $display("FAIL midline_reset got rd=%b rgbi=%h de=%b hs=%b vs=%b exp=0",
               vram_rd, rgbi, de_o, hsync_o, vsync_o);
    end
    test_reset();
    do_cell(14'h005, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1);
    do_cell(14'h005, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1);
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) vram[a] = 8'($urandom);
    for (int a = 0; a < 2048; a++) font[a] = 8'($urandom);
    test_reset();
    test_basic();
    test_reverse();
    test_de_low();
    test_hsync();
    test_blank_cursor_blink();
    test_random();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=bench completion");
    $fatal(1, "watchdog");
  end

endmodule
